// File: rtl/cpu_mem_pkg.sv
// rtl/cpu_mem_pkg.sv - shared memory-map constants and helpers for the CPU memory slice
package cpu_mem_pkg;

  localparam int unsigned WORD_W            = 32;
  localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h1c000000;
  localparam logic [31:0] FETCH_RESET_PC    = 32'h1bfffffc;
  localparam logic [15:0] CNT_MAX           = 16'hffff;

  // Where the visible read data comes from in the response cycle.
  typedef enum logic {
    RESP_ZERO = 1'b0,
    RESP_BANK = 1'b1
  } resp_src_e;

  // Counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == CNT_MAX) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// rtl/sram_bank.sv - byte-enabled read-first synchronous single-port word array
module sram_bank
  import cpu_mem_pkg::*;
#(
  parameter int unsigned DEPTH = 4096,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [3:0]        i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [WORD_W-1:0] i_wdata,
  output logic [WORD_W-1:0] o_rdata
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [WORD_W-1:0] r_rdata;

  // Read-first port: capture the old word and merge enabled lanes on the same edge; output holds when idle.
  always_ff @(posedge clk) begin
    if (i_en) begin
      r_rdata <= r_mem[i_addr];
      for (int b = 0; b < 4; b++) begin
        if (i_we[b]) begin
          r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/inst_sram_resp.sv
// rtl/inst_sram_resp.sv - instruction SRAM responder with decode, error flag, hold and access counters
module inst_sram_resp
  import cpu_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
  parameter int unsigned DEPTH_WORDS = 4096
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              inst_sram_en,
  input  logic [3:0]        inst_sram_we,
  input  logic [31:0]       inst_sram_addr,
  input  logic [WORD_W-1:0] inst_sram_wdata,
  output logic [WORD_W-1:0] inst_sram_rdata,
  output logic              resp_err,
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  // Window end computed in 33 bits so a window touching the top of the address space cannot wrap.
  localparam logic [32:0] END_33  = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
  localparam logic [32:0] BASE_33 = {1'b0, BASE_ADDR};

  logic [32:0]       w_addr_33;
  logic              w_in_range;
  logic              w_aligned;
  logic              w_valid;
  logic [AW-1:0]     w_index;
  logic [WORD_W-1:0] w_bank_rdata;

  resp_src_e         r_src;
  logic              r_err;
  logic [15:0]       r_rd_cnt;
  logic [15:0]       r_wr_cnt;

  assign w_addr_33  = {1'b0, inst_sram_addr};
  assign w_in_range = (w_addr_33 >= BASE_33) && (w_addr_33 < END_33);
  assign w_aligned  = (inst_sram_addr[1:0] == 2'b00);
  assign w_index    = AW'((inst_sram_addr - BASE_ADDR) >> 2);
  // Reset gates the bank so requests during reset never touch the array.
  assign w_valid    = resetn && inst_sram_en && w_in_range && w_aligned;

  sram_bank #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_bank (
    .clk     (clk),
    .i_en    (w_valid),
    .i_we    (inst_sram_we),
    .i_addr  (w_index),
    .i_wdata (inst_sram_wdata),
    .o_rdata (w_bank_rdata)
  );

  // Response source, error flag and saturating counters; source holds when no request so rdata stays stable.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_src    <= RESP_ZERO;
      r_err    <= 1'b0;
      r_rd_cnt <= 16'd0;
      r_wr_cnt <= 16'd0;
    end else begin
      r_err <= inst_sram_en && !w_valid;
      if (inst_sram_en) begin
        r_src <= w_valid ? RESP_BANK : RESP_ZERO;
      end
      if (w_valid && (inst_sram_we == 4'b0000)) begin
        r_rd_cnt <= sat_inc(r_rd_cnt);
      end
      if (w_valid && (inst_sram_we != 4'b0000)) begin
        r_wr_cnt <= sat_inc(r_wr_cnt);
      end
    end
  end

  assign inst_sram_rdata = (r_src == RESP_BANK) ? w_bank_rdata : '0;
  assign resp_err        = r_err;
  assign rd_cnt          = r_rd_cnt;
  assign wr_cnt          = r_wr_cnt;

endmodule

// File: doc/inst_sram_resp.md
INST_SRAM_RESP -- requirements
Module: inst_sram_resp

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1c000000, byte address mapped to word 0 of the array.
REQ-002 Parameter DEPTH_WORDS, default 4096, number of 32-bit words; power of two, minimum 16.
REQ-003 Signal clk  input  1  clock; all state updates on the rising edge.
REQ-004 Signal resetn  input  1  reset, synchronous, active-low.
REQ-005 Signal inst_sram_en  input  1  request strobe; one access per cycle when high.
REQ-006 Signal inst_sram_we  input  4  byte write enables; 4'b0 means read.
REQ-007 Signal inst_sram_addr  input  32  byte address of the access.
REQ-008 Signal inst_sram_wdata  input  32  write data, byte lane i = bits [8i+7:8i].
REQ-009 Signal inst_sram_rdata  output  32  read data, valid in the cycle after the request.
REQ-010 Signal resp_err  output  1  error flag for the access issued in the previous cycle.
REQ-011 Signal rd_cnt  output  16  count of accepted reads, saturating.
REQ-012 Signal wr_cnt  output  16  count of accepted writes, saturating.

Function
REQ-013 The index SHALL be (inst_sram_addr - BASE_ADDR) >> 2, truncated to log2(DEPTH_WORDS) bits after the range check.
REQ-014 The access SHALL be in range when BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS, using 33-bit unsigned comparison, with no wrap past 32'hffffffff.
REQ-015 The access SHALL be misaligned when addr[1:0] != 2'b00.
REQ-016 A read (en=1, we=0) that is in range and aligned SHALL present mem[index] on inst_sram_rdata exactly one cycle later.
REQ-017 A write (en=1, we!=0) that is in range and aligned SHALL update only the enabled byte lanes of mem[index] at that edge.
REQ-018 A write SHALL also return the pre-write word on inst_sram_rdata one cycle later (read-first).
REQ-019 A read in the cycle after a write to the same index SHALL return the written data.
REQ-020 An out-of-range or misaligned access SHALL drive rdata=32'h0 and resp_err=1 one cycle later, and the array SHALL NOT be modified.
REQ-021 With en=0, inst_sram_rdata SHALL hold its last value indefinitely, so a stalled fetch stage reads stable data, and resp_err SHALL go to 0.
REQ-022 resp_err SHALL be 0 one cycle after any valid access.
REQ-023 rd_cnt / wr_cnt SHALL increment by 1 per valid read / write, excluding error accesses, and SHALL hold at 16'hffff.
REQ-024 Back-to-back requests on every cycle SHALL be serviced with no bubble (throughput 1/cycle).

Reset
REQ-025 While resetn=0: rdata=32'h0, resp_err=0, rd_cnt=0, wr_cnt=0, all requests ignored, and the array is not written.
REQ-026 Array contents SHALL NOT be cleared by reset and SHALL survive a mid-operation reset.
REQ-027 A request presented in the same cycle as resetn=0 SHALL produce no response; the first response appears one cycle after the first request with resetn=1.

Structure
REQ-028 Shared package cpu_mem_pkg SHALL hold the BASE_ADDR default, the word width, and the fetch reset PC constant 32'h1bfffffc.
REQ-029 Sub-module sram_bank SHALL implement the byte-enabled, read-first, synchronous single-port array; inst_sram_resp holds the decode, error, hold and counter logic.

Verification
REQ-030 Reset, write 32'hdeadbeef to 0x1c000000 with we=4'hf, then read it -> rdata=32'hdeadbeef one cycle after the read, resp_err=0, wr_cnt=1, rd_cnt=1.
REQ-031 Partial write we=4'b0010 of wdata 32'h0000ab00 over 32'h11223344 at 0x1c000010, then read -> rdata=32'h1122ab44; the write cycle itself returns 32'h11223344.
REQ-032 Read 0x1c000000, then hold en=0 for 5 cycles -> rdata stays 32'hdeadbeef for all 5 cycles, resp_err=0.
REQ-033 Accesses to addr 0x1bfffffc, 0x1c000002, and BASE+4*DEPTH_WORDS, and a write to 0x1c000001 -> each gives rdata=0 and resp_err=1 one cycle later; memory unchanged; counters unchanged.
REQ-034 Preload 65540 valid reads -> rd_cnt saturates at 16'hffff; assert resetn=0 mid-burst -> counters=0, and a following read of 0x1c000000 still returns 32'hdeadbeef.
